// File: rtl/cla_pipe_add.sv
// Pipelined two's-complement adder/subtractor built from 4-bit carry-lookahead segments.
// Optional saturation on signed overflow is enabled by defining CLA_PIPE_ADD_SAT_EN.
module cla_pipe_add #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / 4;
  localparam int unsigned SPS  = NSEG / PIPE;

  logic [WIDTH-1:0] a_q [PIPE];
  logic [WIDTH-1:0] b_q [PIPE];
  logic [WIDTH-1:0] s_q [PIPE];
  logic [PIPE-1:0]  c_q, sub_q, v_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_st [PIPE];
  logic [WIDTH-1:0] b_st [PIPE];
  logic [WIDTH-1:0] s_st [PIPE];
  logic [WIDTH-1:0] s_d  [PIPE];
  logic [PIPE-1:0]  c_st, sub_st, c_d;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;
  logic             advance;

  // Global stall: every register holds while the output beat is not taken.
  assign advance  = !v_q[PIPE-1] | out_ready;
  assign in_ready = advance;

  // Stage inputs: stage 0 sees the ports, stage k sees the registers of stage k-1.
  for (genvar k = 0; k < PIPE; k++) begin : g_feed
    if (k == 0) begin : g_first
      assign a_st[k]   = a;
      assign b_st[k]   = b;
      assign s_st[k]   = '0;
      assign c_st[k]   = op_sub | cin;
      assign sub_st[k] = op_sub;
    end else begin : g_next
      assign a_st[k]   = a_q[k-1];
      assign b_st[k]   = b_q[k-1];
      assign s_st[k]   = s_q[k-1];
      assign c_st[k]   = c_q[k-1];
      assign sub_st[k] = sub_q[k-1];
    end
  end

  always_comb begin
    logic [3:0]  sa, sb, p, g, cv;
    logic        c, gg, gp;
    int unsigned seg;
    for (int unsigned k = 0; k < PIPE; k++) begin
      c      = c_st[k];
      s_d[k] = s_st[k];
      for (int unsigned j = 0; j < SPS; j++) begin
        seg   = k * SPS + j;
        sa    = a_st[k][seg*4 +: 4];
        sb    = b_st[k][seg*4 +: 4] ^ {4{sub_st[k]}};
        p     = sa ^ sb;
        g     = sa & sb;
        cv[0] = c;
        cv[1] = g[0] | (p[0] & c);
        cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        gg    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp    = &p;
        s_d[k][seg*4 +: 4] = p ^ cv;
        c     = gg | (gp & c);
      end
      c_d[k] = c;
    end
  end

  logic sign_a, sign_b;
  assign sign_a = a_st[PIPE-1][WIDTH-1];
  assign sign_b = b_st[PIPE-1][WIDTH-1] ^ sub_st[PIPE-1];
  assign ovf_d  = (sign_a == sign_b) && (s_d[PIPE-1][WIDTH-1] != sign_a);

`ifdef CLA_PIPE_ADD_SAT_EN
  assign sum_d = !ovf_d ? s_d[PIPE-1] :
                 sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_d = s_d[PIPE-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      sub_q <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < PIPE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q[0] <= in_valid;
      for (int unsigned k = 1; k < PIPE; k++) v_q[k] <= v_q[k-1];
      c_q   <= c_d;
      sub_q <= sub_st;
      ovf_q <= ovf_d;
      for (int unsigned k = 0; k < PIPE; k++) begin
        a_q[k] <= a_st[k];
        b_q[k] <= b_st[k];
        s_q[k] <= (k == PIPE - 1) ? sum_d : s_d[k];
      end
    end
  end

  assign out_valid = v_q[PIPE-1];
  assign sum       = s_q[PIPE-1];
  assign cout      = c_q[PIPE-1];
  assign ovf       = ovf_q;

  // Operand copies in the last stage have no consumer.
  logic unused_last;
  assign unused_last = ^{a_q[PIPE-1], b_q[PIPE-1], sub_q[PIPE-1]};

endmodule
